// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the byte-lane clearable RAM.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mem_pkg;

  // Sequencer state: CLEAR sweeps clr_val through every word, IDLE serves the ports.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_state_t;

  // Only one or two read stages are built; anything else is a configuration error.
  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One lane-wide storage array: synchronous write, registered read, no reset.
// Latency: read data registered on the edge that samples re; a same-edge write is not seen (old data).
// Backpressure: none; the caller qualifies we/re.
// Ports: clk; we/w_addr/w_data write port; re/r_addr read port; r_data registered read data.
module mem_bank #(
  parameter int width = 8,
  parameter int depth = 6,
  parameter int aw    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    w_addr,
  input  logic [width-1:0] w_data,
  input  logic             re,
  input  logic [aw-1:0]    r_addr,
  output logic [width-1:0] r_data
);

  (* ram_style = "block" *) logic [width-1:0] mem [0:depth-1];

  // No reset on purpose: contents are defined only by the clear sweep, and the
  // read register is masked by the top level until a valid read lands in it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
    if (re) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/mem_be_clr.sv
// Simple dual-port RAM with byte-lane writes, a hardware clear sweep and 1- or 2-cycle reads.
// Latency: read result and r_valid rd_lat edges after the accepting edge (same edge counts as 1); writes visible next edge.
// Backpressure: none on the ports; while busy is high every read and write is silently dropped.
// Ports: clk, rst_n (async, active low); clr request / busy status;
//        w_enbl, w_be, w_addr, w_data write port; r_enbl, r_addr read request; r_data, r_valid read result.
module mem_be_clr
  import mem_pkg::*;
#(
  parameter int              bits        = 32,
  parameter int              lane        = 8,
  parameter int              words       = 6,
  parameter int              address     = $clog2(words),
  parameter int              rd_lat      = 1,
  parameter bit              write_first = 1'b1,
  parameter logic [bits-1:0] clr_val     = '0,
  localparam int             lanes       = bits / lane
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               busy,
  input  logic               w_enbl,
  input  logic [lanes-1:0]   w_be,
  input  logic [address-1:0] w_addr,
  input  logic [bits-1:0]    w_data,
  input  logic               r_enbl,
  input  logic [address-1:0] r_addr,
  output logic [bits-1:0]    r_data,
  output logic               r_valid
);

  // ---------------------------------------------------------------------------
  // Configuration checks, evaluated at elaboration
  // ---------------------------------------------------------------------------
  if (!rd_lat_legal(rd_lat)) begin : g_bad_rd_lat
    $error("mem_be_clr: rd_lat must be 1 or 2");
  end

  if ((bits % lane) != 0) begin : g_bad_lane
    $error("mem_be_clr: bits must be a multiple of lane");
  end

  localparam logic [address-1:0] last_addr = address'(words - 1);

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  mem_state_t         state;
  mem_state_t         state_nxt;
  logic [address-1:0] clr_ptr;
  logic               sweep_last;
  logic               port_en;

  assign sweep_last = (clr_ptr == last_addr);

  // Reset lands in CLEAR so the array is swept to a known value before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // clr is only looked at in IDLE, so a request during a sweep never restarts it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (sweep_last) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    port_en = 1'b0;
    unique case (state)
      IDLE:    port_en = 1'b1;
      CLEAR:   busy    = 1'b1;
      default: busy    = 1'b1;
    endcase
  end

  // Pointer parks at 0 in IDLE, so an accepted clr always starts the sweep at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr <= '0;
    end else if (state == CLEAR && !sweep_last) begin
      clr_ptr <= clr_ptr + address'(1);
    end else begin
      clr_ptr <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // User port qualification and range check
  // ---------------------------------------------------------------------------
  logic w_ok;
  logic r_ok;
  logic w_go;
  logic r_go;
  logic collide;

  // words need not be a power of two, so the top address codes are out of range.
  assign w_ok    = (32'(w_addr) < words);
  assign r_ok    = (32'(r_addr) < words);
  assign w_go    = port_en & w_enbl & w_ok;
  assign r_go    = port_en & r_enbl;
  // w_go already implies an in-range address, so equality implies a real collision.
  assign collide = w_go & r_go & (w_addr == r_addr);

  // ---------------------------------------------------------------------------
  // Storage: one bank per lane, write port muxed between sweep and user
  // ---------------------------------------------------------------------------
  logic [address-1:0] bank_waddr;
  logic [bits-1:0]    bank_q;

  assign bank_waddr = busy ? clr_ptr : w_addr;

  for (genvar i = 0; i < lanes; i++) begin : g_lane
    logic            lane_we;
    logic [lane-1:0] lane_wd;

    assign lane_we = busy | (w_go & w_be[i]);
    assign lane_wd = busy ? clr_val[i*lane +: lane] : w_data[i*lane +: lane];

    (* ram_style = "block" *)
    mem_bank #(
      .width (lane),
      .depth (words),
      .aw    (address)
    ) u_bank (
      .clk    (clk),
      .we     (lane_we),
      .w_addr (bank_waddr),
      .w_data (lane_wd),
      .re     (r_go & r_ok),
      .r_addr (r_addr),
      .r_data (bank_q[i*lane +: lane])
    );
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: side information registered alongside the bank read
  // ---------------------------------------------------------------------------
  logic             s1_vld;
  logic             s1_ok;
  logic [lanes-1:0] s1_fwd;
  logic [bits-1:0]  s1_wdat;
  logic [bits-1:0]  s1_word;

  // The flags only move on an accepted read, so the stage-1 word (and r_data
  // when rd_lat is 1) holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_ok   <= 1'b0;
      s1_fwd  <= '0;
      s1_wdat <= '0;
    end else begin
      s1_vld <= r_go;
      if (r_go) begin
        s1_ok   <= r_ok;
        // Banks read old data on a collision; write-first patches the written lanes afterwards.
        s1_fwd  <= (write_first && collide) ? w_be : '0;
        s1_wdat <= w_data;
      end
    end
  end

  // s1_ok low also covers the post-reset state, masking the unreset bank registers.
  always_comb begin
    s1_word = '0;
    for (int i = 0; i < lanes; i++) begin
      s1_word[i*lane +: lane] = s1_fwd[i] ? s1_wdat[i*lane +: lane] : bank_q[i*lane +: lane];
    end
    if (!s1_ok) begin
      s1_word = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register stage
  // ---------------------------------------------------------------------------
  if (rd_lat == 2) begin : g_lat2
    logic [bits-1:0] out_q;
    logic            vld_q;

    // A result reaching this stage while a sweep runs is discarded: after a
    // clear no stale pre-clear data may be reported as a fresh read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= s1_vld & port_en;
        if (s1_vld && port_en) begin
          out_q <= s1_word;
        end
      end
    end

    assign r_data  = out_q;
    assign r_valid = vld_q;
  end else begin : g_lat1
    assign r_data  = s1_word;
    assign r_valid = s1_vld;
  end

endmodule

// File: doc/mem_be_clr.md
# mem_be_clr

Parametrised simple dual-port block RAM: one write port and one read port on a single clock. Adds byte-lane write enables, selectable read latency (1 or 2), a same-address read-during-write policy and a hardware clear sequencer that fills the array after reset or on request. It is the next-generation buffer for systolic-array operand and result storage; `busy` gates upstream producers until the array is in a known state.

## Interface
- `bits`, 32: word width; must be a multiple of `lane`.
- `lane`, 8: byte-lane width; `lanes = bits/lane`.
- `words`, 6: depth; need not be a power of two.
- `address`, `$clog2(words)`: address width.
- `rd_lat`, 1: read latency in cycles; legal values 1 or 2.
- `write_first`, 1: 1 returns new data on a same-address collision; 0 returns old data.
- `clr_val`, 0: word written to every location by the clear sequencer.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: clear request, sampled only in IDLE.
- `busy` out 1: clear in progress; port traffic is ignored while high.
- `w_enbl` in 1: write strobe.
- `w_be` in `lanes`: per-lane write enable, qualified by `w_enbl`.
- `w_addr` in `address`: write address.
- `w_data` in `bits`: write data.
- `r_enbl` in 1: read strobe.
- `r_addr` in `address`: read address.
- `r_data` out `bits`: read data; holds its value between reads.
- `r_valid` out 1: one-cycle pulse marking new `r_data`.

## Operation
- **FSM states:** IDLE and CLEAR.
- **Reset:** reset enters CLEAR with `clr_ptr=0`. Reset values: `busy=1`, `r_data=0`, `r_valid=0`, all read pipeline stages cleared.
- **CLEAR:** each edge writes `clr_val` to `clr_ptr`, all lanes, then increments the pointer. The edge that writes `words-1` moves the FSM to IDLE and drops `busy`.
- **Clear request:** IDLE with `clr` high moves to CLEAR with `clr_ptr=0`. `clr` is ignored in CLEAR; it does not restart the sweep.
- **Traffic during CLEAR:** user writes are dropped, user reads are dropped (no `r_valid`), and in-flight `rd_lat=2` reads are flushed.
- **Reset mid-clear:** restarts the sweep at 0. Array contents are not reset asynchronously; only the sweep defines them.
- **Write:** with `w_enbl=1`, each lane `i` with `w_be[i]=1` is written with `w_data[i*lane +: lane]`; other lanes keep their contents.
- **Out-of-range addresses (`addr >= words`):** a write is ignored. A read returns 0 with `r_valid` still pulsed.
- **Same-address collision** (read and write to one address in the same cycle):
  - `write_first=1`: returned lanes with `w_be=1` carry the new data; other lanes carry the old contents.
  - `write_first=0`: all lanes carry the old contents.
- **Back-to-back reads:** fully pipelined, one result per cycle, in request order.

## Timing
- A read accepted at edge t: `r_data`/`r_valid` update at edge t+`rd_lat`.
- With `rd_lat=2`, the second stage is an output register.
- A write at edge t is visible to a read accepted at edge t+1. At edge t itself, the collision policy applies.
- `busy` is high for exactly `words` cycles after reset release, and for `words` cycles starting the cycle after `clr` is accepted.
- The first user access is accepted on the first edge with `busy=0`.

## Structure
- **Package `mem_pkg`:** FSM state enum `mem_state_t {IDLE, CLEAR}` and the `rd_lat` legality check, implemented as a function used by an elaboration-time assertion.
- **Sub-module `mem_bank`:** one lane-wide storage array with a registered read. It has no reset; it is instantiated `lanes` times via generate, each carrying the `ram_style="block"` attribute.
- **Top level owns:**
  - the FSM and `clr_ptr`;
  - the write mux (sequencer vs user);
  - collision detection, registered alongside the read address;
  - the range check;
  - the `rd_lat` pipeline and valid shift register.

## Test plan
All scenarios use `bits=32`, `lane=8`, `words=6`, `clr_val=0` unless stated.
- **Reset/clear:** release `rst_n` → `busy` high for 6 cycles; a read of address 5 then returns `32'h0` with `r_valid` one cycle later (`rd_lat=1`).
- **Byte lanes:**
  1. Write `32'hAABBCCDD` to address 2 with `w_be=4'hF`.
  2. Write `32'h11223344` to address 2 with `w_be=4'b0101`.
  3. Read address 2 → `32'hAA22CC44`.
- **Collision:** with address 3 holding `32'h0`, write `32'hDEADBEEF` (`w_be=4'b0011`) and read address 3 in the same cycle.
  - `write_first=1` → `32'h0000BEEF`.
  - `write_first=0` → `32'h00000000`.
- **Latency/streaming (`rd_lat=2`):** reads of addresses 0,1,2,3 on consecutive edges → `r_valid` high for 4 consecutive cycles starting 2 edges after the first read, data in order.
- **Out of range:** write `32'h12345678` to address 7, then read address 7 → `32'h0`, `r_valid=1`; addresses 0–5 are unchanged.
- **Mid-operation clear/reset:**
  - Pulse `clr` with a `rd_lat=2` read in flight → no `r_valid`, `busy` high 6 cycles, then all words read `clr_val`.
  - Assert `rst_n=0` mid-sweep → the sweep restarts from 0.
